// File: rtl/dot8_pkg.sv
// Shared constants and state type for the serial eight-term dot-product engine.
package dot8_pkg;

    localparam int unsigned DOT8_N_TERMS = 8;
    localparam int unsigned DOT8_IN_W    = 6;
    localparam int unsigned DOT8_OUT_W   = 9;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_e;

endpackage : dot8_pkg

// File: rtl/dot8_mac_step.sv
// One multiply-accumulate step: acc + low OUT_W bits of the signed product a*b.
module dot8_mac_step #(
    parameter int unsigned IN_W  = 6,
    parameter int unsigned OUT_W = 9
) (
    input  logic        [OUT_W-1:0] acc_i,
    input  logic signed [IN_W-1:0]  a_i,
    input  logic signed [IN_W-1:0]  b_i,
    output logic        [OUT_W-1:0] sum_o
);

    localparam int unsigned PROD_W = 2 * IN_W;
    // Wide enough to sign-extend the product when OUT_W exceeds it.
    localparam int unsigned EXT_W  = (OUT_W > PROD_W) ? OUT_W : PROD_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [EXT_W-1:0]  prod_ext;

    // Full-precision signed product, sign-extended, then truncated into the sum.
    always_comb begin
        prod     = PROD_W'(a_i) * PROD_W'(b_i);
        prod_ext = EXT_W'(prod);
        sum_o    = acc_i + OUT_W'(prod_ext);
    end

endmodule : dot8_mac_step

// File: rtl/dot8_serial_mac.sv
// Streaming dot-product engine: accumulates N_TERMS signed pairs, then offers
// the wrapped OUT_W-bit sum on a valid/ready result port.
module dot8_serial_mac
    import dot8_pkg::*;
#(
    parameter int unsigned N_TERMS = DOT8_N_TERMS,
    parameter int unsigned IN_W    = DOT8_IN_W,
    parameter int unsigned OUT_W   = DOT8_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_a,
    input  logic signed [IN_W-1:0]  in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_q
);

    localparam int unsigned     CNT_W    = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   step_sum;
    logic               in_ready_q;
    logic               out_valid_q;

    dot8_mac_step #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_step (
        .acc_i (acc_q),
        .a_i   (in_a),
        .b_i   (in_b),
        .sum_o (step_sum)
    );

    // Next-state logic: flush clears everything; ACC accepts pairs, DONE waits for the sink.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ACC: begin
                    // in_ready is asserted exactly in ACC, so in_valid alone is the handshake.
                    if (in_valid) begin
                        acc_d = step_sum;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = ACC;
                        acc_d   = '0;
                    end
                end
                default: begin
                    state_d = ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, datapath and registered handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == ACC);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_q     = $signed(acc_q);

endmodule : dot8_serial_mac

// File: tb/tb_dot8_serial_mac.sv
// Self-checking bench for dot8_serial_mac: reference model on plain integer sums
// plus directed vectors with hand-computed results.
module tb_dot8_serial_mac;
    import dot8_pkg::*;

    localparam int unsigned N     = DOT8_N_TERMS;
    localparam int unsigned IN_W  = DOT8_IN_W;
    localparam int unsigned OUT_W = DOT8_OUT_W;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_a;
    logic signed [IN_W-1:0]  in_b;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_q;

    int checks = 0;
    int errors = 0;

    dot8_serial_mac dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collects accepted products, result = integer sum mod 2^OUT_W.
    int               m_terms[$];
    bit               m_pending = 1'b0;
    logic [OUT_W-1:0] m_val = '0;
    bit               m_live = 1'b0;
    int               m_sum;

    always @(posedge clk) begin
        if (rst || flush) begin
            m_terms.delete();
            m_pending = 1'b0;
            if (rst) m_live = 1'b1;
        end else if (m_pending) begin
            if (out_ready) m_pending = 1'b0;
        end else if (in_valid) begin
            m_terms.push_back(int'(in_a) * int'(in_b));
            if (m_terms.size() == N) begin
                m_sum = 0;
                foreach (m_terms[k]) m_sum += m_terms[k];
                m_val     = OUT_W'(m_sum);
                m_pending = 1'b1;
                m_terms.delete();
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("cyc_in_ready", int'(in_ready), int'(!m_pending));
            chk("cyc_out_valid", int'(out_valid), int'(m_pending));
            if (m_pending) chk("cyc_out_q", int'(out_q), int'($signed(m_val)));
        end
    end

    task automatic send_pair(input int a, input int b);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = IN_W'(a);
            in_b     = IN_W'(b);
            if (in_ready) return;
        end
        checks++;
        errors++;
        $display("FAIL send_pair_timeout actual=no_ready required=ready t=%0t", $time);
    endtask

    task automatic send_vec(input int a, input int b, input int n);
        for (int i = 0; i < n; i++) send_pair(a, b);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get_result(input int exp, input string name);
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                chk(name, int'(out_q), exp);
                chk({name, "_model"}, int'($signed(m_val)), exp);
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout actual=no_valid required=valid t=%0t", name, $time);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_q", int'(out_q), 0);
        rst = 1'b0;

        // All ones: result timing and return to ACC.
        send_vec(1, 1, N);
        chk("t1_out_valid", int'(out_valid), 1);
        chk("t1_in_ready_low", int'(in_ready), 0);
        chk("t1_out_q", int'(out_q), 8);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t1_in_ready_back", int'(in_ready), 1);
        chk("t1_out_valid_low", int'(out_valid), 0);

        // Wrapping and sign cases.
        send_vec(31, 31, N);
        get_result(8, "t2_31x31");
        send_vec(-32, -32, N);
        get_result(0, "t2_m32xm32");
        send_vec(-1, 5, N);
        get_result(-40, "t2_m1x5");

        // Back-pressure: result held, inputs ignored.
        send_vec(3, -2, N);
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_q", int'(out_q), -48);
            chk("t3_hold_ready", int'(in_ready), 0);
            in_valid = k[0];
            in_a     = IN_W'(9);
            in_b     = IN_W'(9);
            @(negedge clk);
        end
        in_valid = 1'b0;
        get_result(-48, "t3_result");
        send_vec(1, 1, N);
        get_result(8, "t3_next_vec");

        // Flush mid-vector discards the partial sum.
        for (int k = 0; k < 3; k++) send_pair(7, 7);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        send_vec(2, 3, N);
        get_result(48, "t4_after_flush");

        // Flush coinciding with an input handshake drops that pair.
        send_pair(5, 5);
        send_pair(5, 5);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_a     = IN_W'(7);
        in_b     = IN_W'(7);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        send_vec(1, 1, N);
        get_result(8, "t4_flush_hs");

        // Flush alongside out_ready in DONE drops the result.
        send_vec(2, 3, N);
        chk("t5_pre_valid", int'(out_valid), 1);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("t5_dropped_valid", int'(out_valid), 0);
        chk("t5_dropped_ready", int'(in_ready), 1);
        send_vec(1, 2, N);
        get_result(16, "t5_next_vec");

        // Reset mid-vector.
        for (int k = 0; k < 5; k++) send_pair(1, 1);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_in_ready", int'(in_ready), 1);
        chk("t6_rst_out_valid", int'(out_valid), 0);
        chk("t6_rst_out_q", int'(out_q), 0);
        send_vec(1, -1, N);
        get_result(-8, "t6_1xm1");

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dot8_serial_mac

// File: doc/dot8_serial_mac.md
# dot8_serial_mac

Sequential dot-product engine. It accepts N_TERMS signed operand pairs one per cycle over a valid/ready stream and accumulates their products. It then presents the two's-complement sum truncated to OUT_W bits on a valid/ready result port. It is the streaming consumer-side counterpart of the combinational eight-term dot product, and it serves as the sequential design point for word-level equivalence benchmarks.

## Interface
Parameters:
- N_TERMS, 8, products per result (≥2)
- IN_W, 6, signed operand width
- OUT_W, 9, signed result width; the result is the sum modulo 2^OUT_W

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous abort; discards any partial sum or pending result
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept a pair
- in_a  input  IN_W  signed operand
- in_b  input  IN_W  signed operand
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_q  output  OUT_W  signed result

## Operation
- States: ACC, DONE.
- ACC:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: acc <= acc + sext(in_a*in_b) truncated to OUT_W; cnt <= cnt+1.
  - On the handshake with cnt==N_TERMS-1: go to DONE, with cnt <= 0.
- DONE:
  - in_ready=0, out_valid=1, out_q=acc (registered, held stable).
  - On out_valid&&out_ready: go to ACC with acc <= 0.
- Arithmetic:
  - The product is a full 2*IN_W signed value. Only its low OUT_W bits enter the accumulator.
  - The accumulator is OUT_W bits and wraps silently.
  - The result is bit-identical to the combinational sum of all products truncated to OUT_W.
- flush:
  - Highest priority after rst.
  - Next state is ACC with acc=0 and cnt=0, in any state.
  - A handshake on the same cycle is discarded: the pair is not accumulated, or the result is dropped.
- rst: same effect as flush. All outputs are at reset values on the cycle after rst.
- in_valid with in_ready=0 has no effect. The source must hold the pair; the block does not check this.
- out_ready while out_valid=0 has no effect.

## Timing
- Reset values: in_ready=1, out_valid=0, out_q=0, internal acc=0, cnt=0, state=ACC.
- Latency: out_valid rises on the cycle after the N_TERMS-th accepted pair.
- Throughput: one pair per cycle in ACC. Minimum period per result is N_TERMS+1 cycles.
- No input acceptance occurs in DONE, including on the cycle out_ready is asserted. The first pair of the next vector is accepted one cycle later.
- out_q and out_valid are driven from registers only; there is no combinational path from inputs.
- in_ready depends on state only.
- Back-pressure: out_q is held indefinitely while out_ready=0.
- Counter width is $clog2(N_TERMS). The counter wraps only via the explicit clear above and never overflows.

## Structure
- Shared package dot8_pkg holds:
  - the default constants N_TERMS=8, IN_W=6, OUT_W=9
  - the state enum type (ACC, DONE)
- One sub-module, dot8_mac_step: combinational, takes acc, a and b, and returns acc + truncated product. It is reusable by the combinational reference model for equivalence.
- The top level holds the FSM, counter, accumulator register and handshakes.

## Test plan
- All 8 pairs a=1, b=1, out_ready=1 -> out_valid on the cycle after the 8th handshake, out_q=8; in_ready=1 again 2 cycles after the 8th handshake.
- All pairs a=31, b=31 -> out_q=8 (7688 mod 512). All pairs a=-32, b=-32 -> out_q=0 (8192 mod 512).
- All pairs a=-1, b=5 -> out_q=-40 (9'h1D8).
- out_ready low for 5 cycles after the result -> out_q stable, in_ready=0 throughout, and in_valid pulses are ignored. Then out_ready high -> one transfer, next vector accumulates from 0.
- 3 pairs of 7*7, then flush, then 8 pairs of 2*3 -> out_q=48. Repeat with flush raised in the DONE cycle alongside out_ready -> result dropped, out_valid=0 the next cycle.
- rst asserted after 5 accepted pairs -> all outputs at reset values the next cycle. A subsequent full vector of a=1, b=-1 -> out_q=-8.
